// File: rtl/spi_wave_buffer_pkg.sv
// -----------------------------------------------------------------------------
// spi_wave_buffer_pkg
// Shared constants, frame-FSM state type and the status-word helper for the
// SPI-loaded double-buffered waveform table.
// -----------------------------------------------------------------------------
package spi_wave_buffer_pkg;

    localparam int          DW           = 14;     // sample width (DAC width)
    localparam int          AW           = 7;      // address width per bank
    localparam int          DEPTH        = 98;     // samples per table
    localparam logic [7:0]  HDR          = 8'hA5;  // required command header byte
    localparam logic [7:0]  STATUS_MAGIC = 8'h5A;  // marker in the status word
    localparam int          WORD_W       = 16;     // SPI word width
    localparam int          BIT_CW       = 4;      // bit counter width (0..15)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DROP
    } frame_state_t;

    // Status returned on miso during the command word.
    function automatic logic [WORD_W-1:0] status_word(
        input logic last_ok,
        input logic pending,
        input logic bank
    );
        return {STATUS_MAGIC, 5'd0, last_ok, pending, bank};
    endfunction

endpackage

// File: rtl/spi_wave_buffer_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 slave front end running entirely in the clk domain.
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi raw SPI pins (asynchronous to clk)
//   status            word to shift out on miso during the first word of a frame
//   spi_miso          serial status output, updated on sclk falling edges
//   word_valid        one-clk strobe, word_data holds a complete 16-bit word
//   cs_fall/cs_rise   one-clk frame start / frame end strobes
// -----------------------------------------------------------------------------
module spi_slave_rx
    import spi_wave_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    input  logic [WORD_W-1:0] status,
    output logic              spi_miso,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              cs_fall,
    output logic              cs_rise
);

    logic [1:0]        sclk_sync_reg;
    logic [1:0]        cs_sync_reg;
    logic [1:0]        mosi_sync_reg;
    logic              sclk_prev_reg;
    logic              cs_prev_reg;
    logic              in_frame_reg;
    logic [BIT_CW-1:0] bit_cnt_reg;
    logic [WORD_W-1:0] rx_shift_reg;
    logic [WORD_W-1:0] tx_shift_reg;
    logic              miso_reg;
    logic              word_valid_reg;
    logic [WORD_W-1:0] word_data_reg;

    logic sclk_rise;
    logic sclk_fall;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_prev_reg;

    // cs synchroniser resets to "selected" so that a cs_n already high at
    // reset release only produces a raw rising edge, which is discarded
    // because no frame is open. A frame therefore only ever begins on a
    // genuine high-to-low transition observed after reset.
    assign cs_fall = ~cs_sync_reg[1] & cs_prev_reg;
    assign cs_rise = cs_sync_reg[1] & ~cs_prev_reg & in_frame_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= 2'b00;
            cs_sync_reg   <= 2'b00;
            mosi_sync_reg <= 2'b00;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk};
            cs_sync_reg   <= {cs_sync_reg[0], spi_cs_n};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
            sclk_prev_reg <= sclk_sync_reg[1];
            cs_prev_reg   <= cs_sync_reg[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_reg   <= 1'b0;
            bit_cnt_reg    <= '0;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            miso_reg       <= 1'b0;
            word_valid_reg <= 1'b0;
            word_data_reg  <= '0;
        end else begin
            word_valid_reg <= 1'b0;
            if (cs_fall) begin
                // First status bit must be on miso before the first sclk rise.
                in_frame_reg <= 1'b1;
                bit_cnt_reg  <= '0;
                miso_reg     <= status[WORD_W-1];
                tx_shift_reg <= {status[WORD_W-2:0], 1'b0};
            end else if (cs_rise) begin
                in_frame_reg <= 1'b0;
                bit_cnt_reg  <= '0;
                miso_reg     <= 1'b0;
                tx_shift_reg <= '0;
            end else if (in_frame_reg) begin
                if (sclk_rise) begin
                    rx_shift_reg <= {rx_shift_reg[WORD_W-2:0], mosi_sync_reg[1]};
                    bit_cnt_reg  <= bit_cnt_reg + BIT_CW'(1);
                    if (bit_cnt_reg == BIT_CW'(WORD_W - 1)) begin
                        word_valid_reg <= 1'b1;
                        word_data_reg  <= {rx_shift_reg[WORD_W-2:0], mosi_sync_reg[1]};
                    end
                end
                // Zeros shift in behind the status, so miso reads 0 after word0.
                if (sclk_fall) begin
                    miso_reg     <= tx_shift_reg[WORD_W-1];
                    tx_shift_reg <= {tx_shift_reg[WORD_W-2:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso   = miso_reg;
    assign word_valid = word_valid_reg;
    assign word_data  = word_data_reg;

endmodule

// File: rtl/spi_wave_buffer.sv
// -----------------------------------------------------------------------------
// spi_wave_buffer
// Double-buffered waveform table loaded over SPI, read by the DAC stage.
//   clk, rst_n        system/DAC clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi SPI slave inputs (mode 0, MSB first)
//   spi_miso          status word during the command word, 0 afterwards
//   rd_addr, rd_data  DAC read port, one-cycle latency, 0 outside the table
//   swap_pending      a committed table waits for rd_addr==0 to go live
//   frame_err         one-clk pulse when a frame is rejected
// -----------------------------------------------------------------------------
module spi_wave_buffer
    import spi_wave_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_sclk,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          swap_pending,
    output logic          frame_err
);

    localparam int          MEM_DEPTH = 2 ** (AW + 1);
    localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH);

    frame_state_t  state_reg, state_next;
    logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
    logic          swap_pending_reg;
    logic          active_bank_reg;
    logic          last_ok_reg;
    logic          frame_err_reg;
    logic [DW-1:0] rd_data_reg;

    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              cs_fall;
    logic              cs_rise;

    logic wr_en;
    logic commit;
    logic reject;
    logic swap_now;
    logic rd_bank;

    // Both banks live in one array; the bank bit is the address MSB.
    logic [DW-1:0] mem [MEM_DEPTH];

    spi_slave_rx u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .status     (status_word(last_ok_reg, swap_pending_reg, active_bank_reg)),
        .spi_miso   (spi_miso),
        .word_valid (word_valid),
        .word_data  (word_data),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise)
    );

    assign swap_now = swap_pending_reg && (rd_addr == '0);
    // The read issued in the swap cycle already sees the new table, so a
    // full period starting at address 0 is never torn.
    assign rd_bank  = active_bank_reg ^ swap_now;

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        wr_en       = 1'b0;
        commit      = 1'b0;
        reject      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    wr_cnt_next = '0;
                    // A swap in this same cycle frees the shadow bank.
                    state_next  = (swap_pending_reg && !swap_now) ? ST_DROP : ST_HDR;
                end
            end
            ST_HDR: begin
                if (cs_rise) begin
                    reject     = 1'b1;
                    state_next = ST_IDLE;
                end else if (word_valid) begin
                    state_next = (word_data[15:8] == HDR) ? ST_DATA : ST_DROP;
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    commit     = (wr_cnt_reg == LAST_CNT);
                    reject     = (wr_cnt_reg != LAST_CNT);
                    state_next = ST_IDLE;
                end else if (word_valid) begin
                    if (wr_cnt_reg == LAST_CNT) begin
                        state_next = ST_DROP;
                    end else begin
                        wr_en       = 1'b1;
                        wr_cnt_next = wr_cnt_reg + AW'(1);
                    end
                end
            end
            ST_DROP: begin
                if (cs_rise) begin
                    reject     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            wr_cnt_reg       <= '0;
            swap_pending_reg <= 1'b0;
            active_bank_reg  <= 1'b0;
            last_ok_reg      <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            frame_err_reg <= reject;
            if (swap_now) begin
                active_bank_reg  <= ~active_bank_reg;
                swap_pending_reg <= 1'b0;
            end else if (commit) begin
                swap_pending_reg <= 1'b1;
            end
            if (commit) begin
                last_ok_reg <= 1'b1;
            end else if (reject) begin
                last_ok_reg <= 1'b0;
            end
        end
    end

    // Shadow bank is always the inactive one; no swap can occur while a
    // frame is in DATA because a pending table blocks new frames.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~active_bank_reg, wr_cnt_reg}] <= word_data[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_addr < LAST_CNT) begin
            rd_data_reg <= mem[{rd_bank, rd_addr}];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign rd_data      = rd_data_reg;
    assign swap_pending = swap_pending_reg;
    assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_spi_wave_buffer.sv
// -----------------------------------------------------------------------------
// tb_spi_wave_buffer
// Directed bench for spi_wave_buffer: SPI frames driven at sclk = clk/8,
// DAC reads swept over the table, frame_err pulses counted on negedge.
// -----------------------------------------------------------------------------
module tb_spi_wave_buffer;

    logic       clk;
    logic       rst_n;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [6:0] rd_addr;
    logic [13:0] rd_data;
    logic       swap_pending;
    logic       frame_err;

    int n_cmp;
    int n_bad;
    int err_cnt;
    int exp_err;

    logic [15:0] stat;
    logic [15:0] tail;
    logic [15:0] junk;

    spi_wave_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .swap_pending (swap_pending),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected table contents, one formula per table id.
    function automatic logic [13:0] tbl_val(input int t, input int k);
        int v;
        case (t)
            0:       v = k * 100;
            1:       v = k * 37 + 11;
            2:       v = 16383 - k * 53;
            default: v = k * 150 + 5;
        endcase
        return v[13:0];
    endfunction

    // Shift nbits of w MSB first; miso is captured just before each sclk rise.
    task automatic spi_word(input logic [15:0] w, input int nbits, output logic [15:0] r);
        r = '0;
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = w[15-b];
            wait_clk(4);
            r = {r[14:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int t, input int nsamp,
                              input int extra_bits,
                              output logic [15:0] st, output logic [15:0] tl);
        logic [15:0] r;
        spi_cs_n = 1'b0;
        wait_clk(8);
        spi_word({hdr, 8'h00}, 16, st);
        tl = '0;
        for (int k = 0; k < nsamp; k++) begin
            spi_word({2'b10, tbl_val(t, k)}, 16, r);
            tl = tl | r;
        end
        if (extra_bits > 0) spi_word({2'b01, tbl_val(t, nsamp)}, extra_bits, r);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(8);
        $display("frame hdr=%02h table=%0d samples=%0d extra_bits=%0d status=%04h",
                 hdr, t, nsamp, extra_bits, st);
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [13:0] exp);
        rd_addr = addr[6:0];
        wait_clk(1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    // Full read sweep from address 0; the first read takes any pending swap.
    task automatic sweep(input string tag, input int t);
        for (int k = 0; k < 98; k++) begin
            read_chk($sformatf("%s_rd%0d", tag, k), k, tbl_val(t, k));
            if (k == 0) chk({tag, "_pending_after_swap"}, 32'(swap_pending), 0);
        end
        rd_addr = 7'd1;
        $display("sweep %s table=%0d done", tag, t);
    endtask

    task automatic spot_a(input string tag);
        read_chk({tag, "_a0"}, 0, tbl_val(0, 0));
        read_chk({tag, "_a49"}, 49, tbl_val(0, 49));
        read_chk({tag, "_a50"}, 50, tbl_val(0, 50));
        read_chk({tag, "_a97"}, 97, tbl_val(0, 97));
        rd_addr = 7'd1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; err_cnt = 0; exp_err = 0;
        rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        rd_addr = 7'd1;
        wait_clk(4);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_pending", 32'(swap_pending), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_miso", 32'(spi_miso), 0);
        rst_n = 1'b1;
        wait_clk(4);

        // 1: valid frame k*100, swap at next rd_addr==0
        send_frame(8'hA5, 0, 98, 0, stat, tail);
        chk("t1_status", 32'(stat), 32'h5A00);
        chk("t1_miso_tail", 32'(tail), 0);
        chk("t1_pending", 32'(swap_pending), 1);
        chk("t1_err", err_cnt, exp_err);
        sweep("t1", 0);
        read_chk("t1_oob98", 98, 14'd0);
        read_chk("t1_oob127", 127, 14'd0);
        rd_addr = 7'd1;

        // 2 + status readback: bad header, full sample count
        send_frame(8'h5A, 2, 98, 0, stat, tail);
        exp_err++;
        chk("t2_status", 32'(stat), 32'h5A05);
        chk("t2_miso_tail", 32'(tail), 0);
        chk("t2_err", err_cnt, exp_err);
        chk("t2_pending", 32'(swap_pending), 0);
        spot_a("t2");

        // 3: 97 and 99 samples
        send_frame(8'hA5, 1, 97, 0, stat, tail);
        exp_err++;
        chk("t3a_status", 32'(stat), 32'h5A01);
        chk("t3a_err", err_cnt, exp_err);
        chk("t3a_pending", 32'(swap_pending), 0);
        spot_a("t3a");
        send_frame(8'hA5, 1, 99, 0, stat, tail);
        exp_err++;
        chk("t3b_err", err_cnt, exp_err);
        chk("t3b_pending", 32'(swap_pending), 0);
        spot_a("t3b");

        // 4: cs_n raised after 9 bits of sample 50
        send_frame(8'hA5, 2, 50, 9, stat, tail);
        exp_err++;
        chk("t4_err", err_cnt, exp_err);
        chk("t4_pending", 32'(swap_pending), 0);
        spot_a("t4");

        // 5: valid frame, then a second frame while the first is pending
        send_frame(8'hA5, 1, 98, 0, stat, tail);
        chk("t5a_status", 32'(stat), 32'h5A01);
        chk("t5a_err", err_cnt, exp_err);
        chk("t5a_pending", 32'(swap_pending), 1);
        send_frame(8'hA5, 2, 8, 0, stat, tail);
        exp_err++;
        chk("t5b_status", 32'(stat), 32'h5A07);
        chk("t5b_err", err_cnt, exp_err);
        chk("t5b_pending", 32'(swap_pending), 1);
        sweep("t5", 1);

        // 6: reset in the middle of a frame
        spi_cs_n = 1'b0;
        wait_clk(8);
        spi_word({8'hA5, 8'h00}, 16, junk);
        for (int k = 0; k < 10; k++) spi_word({2'b00, tbl_val(2, k)}, 16, junk);
        rst_n = 1'b0;
        wait_clk(3);
        chk("t6_rst_rd_data", 32'(rd_data), 0);
        chk("t6_rst_pending", 32'(swap_pending), 0);
        chk("t6_rst_frame_err", 32'(frame_err), 0);
        chk("t6_rst_miso", 32'(spi_miso), 0);
        wait_clk(2);
        rst_n = 1'b1;
        for (int k = 10; k < 13; k++) spi_word({2'b00, tbl_val(2, k)}, 16, junk);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(8);
        $display("aborted frame ended after reset");
        chk("t6_abort_err", err_cnt, exp_err);
        chk("t6_abort_pending", 32'(swap_pending), 0);
        send_frame(8'hA5, 3, 98, 0, stat, tail);
        chk("t6_status", 32'(stat), 32'h5A00);
        chk("t6_err", err_cnt, exp_err);
        chk("t6_pending", 32'(swap_pending), 1);
        sweep("t6", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
